// File: rtl/xalu_ise_arb_if.sv
// Requester-side bundle for xalu_ise_arb: one issue handshake carrying an operation
// (fn/imm/in1/in2) and one response handshake returning the result.
//   master : the requester (drives req_val, operation fields, rsp_rdy)
//   slave  : the arbiter   (drives req_rdy, rsp_val, rsp_out, rsp_err)
interface xalu_ise_arb_if #(
  parameter int unsigned XLEN = 64
);
  logic            req_val;
  logic            req_rdy;
  logic [4:0]      fn;
  logic [6:0]      imm;
  logic [XLEN-1:0] in1;
  logic [XLEN-1:0] in2;
  logic            rsp_val;
  logic            rsp_rdy;
  logic [XLEN-1:0] rsp_out;
  logic            rsp_err;

  modport master (
    output req_val, fn, imm, in1, in2, rsp_rdy,
    input  req_rdy, rsp_val, rsp_out, rsp_err
  );

  modport slave (
    input  req_val, fn, imm, in1, in2, rsp_rdy,
    output req_rdy, rsp_val, rsp_out, rsp_err
  );
endinterface

// File: rtl/xalu_ise_arb.sv
// Round-robin arbiter sharing one xalu_ise between requester 0 (scalar pipe) and
// requester 1 (key-exchange sequencer). An accepted operation is registered, driven to the
// ALU for exactly one cycle, and its result (or zero + error when the ALU does not
// recognise the encoding) is held on the owner's response port until consumed.
// Ports:
//   ise_clk, ise_rst  clock, asynchronous active-high reset
//   req0, req1        requester bundles (issue + response handshakes)
//   alu_fn/imm/in1/in2/val  registered drive to xalu_ise
//   alu_oval, alu_out       combinational result from xalu_ise
//   ops_done          count of consumed responses (wraps)
//   busy              an operation is in flight or awaiting consumption
module xalu_ise_arb #(
  parameter int unsigned XLEN    = 64,
  parameter bit          RR_INIT = 1'b0,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             ise_clk,
  input  logic             ise_rst,
  xalu_ise_arb_if.slave    req0,
  xalu_ise_arb_if.slave    req1,
  output logic [4:0]       alu_fn,
  output logic [6:0]       alu_imm,
  output logic [XLEN-1:0]  alu_in1,
  output logic [XLEN-1:0]  alu_in2,
  output logic             alu_val,
  input  logic             alu_oval,
  input  logic [XLEN-1:0]  alu_out,
  output logic [CNT_W-1:0] ops_done,
  output logic             busy
);

  typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

  state_e          state_q;
  logic            prio_q;   // requester that wins a tie
  logic            owner_q;  // requester whose op is in flight
  logic            rsp0_val_q, rsp1_val_q;
  logic            rsp0_err_q, rsp1_err_q;
  logic [XLEN-1:0] rsp0_out_q, rsp1_out_q;
  logic [CNT_W-1:0] ops_done_q;

  logic grant0, grant1;
  logic consume;

  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (state_q == StIdle) begin
      if (req0.req_val && (!req1.req_val || !prio_q)) begin
        grant0 = 1'b1;
      end else if (req1.req_val) begin
        grant1 = 1'b1;
      end
    end
  end

  assign consume = (state_q == StResp) &&
                   (owner_q ? (rsp1_val_q && req1.rsp_rdy) : (rsp0_val_q && req0.rsp_rdy));

  assign req0.req_rdy = grant0;
  assign req1.req_rdy = grant1;
  assign req0.rsp_val = rsp0_val_q;
  assign req0.rsp_out = rsp0_out_q;
  assign req0.rsp_err = rsp0_err_q;
  assign req1.rsp_val = rsp1_val_q;
  assign req1.rsp_out = rsp1_out_q;
  assign req1.rsp_err = rsp1_err_q;
  assign ops_done     = ops_done_q;
  assign busy         = (state_q != StIdle);

  // The alu_* registers double as the operand latch: loaded on grant, visible during
  // EXEC, cleared when leaving EXEC so the ALU sees zeros whenever it is not in use.
  always_ff @(posedge ise_clk or posedge ise_rst) begin
    if (ise_rst) begin
      state_q    <= StIdle;
      prio_q     <= RR_INIT;
      owner_q    <= 1'b0;
      rsp0_val_q <= 1'b0;
      rsp1_val_q <= 1'b0;
      rsp0_err_q <= 1'b0;
      rsp1_err_q <= 1'b0;
      rsp0_out_q <= '0;
      rsp1_out_q <= '0;
      alu_fn     <= '0;
      alu_imm    <= '0;
      alu_in1    <= '0;
      alu_in2    <= '0;
      alu_val    <= 1'b0;
      ops_done_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (grant0 || grant1) begin
            owner_q <= grant1;
            prio_q  <= ~grant1;
            alu_fn  <= grant1 ? req1.fn  : req0.fn;
            alu_imm <= grant1 ? req1.imm : req0.imm;
            alu_in1 <= grant1 ? req1.in1 : req0.in1;
            alu_in2 <= grant1 ? req1.in2 : req0.in2;
            alu_val <= 1'b1;
            state_q <= StExec;
          end
        end
        StExec: begin
          // Only the owner's response registers change; the other port is left alone.
          if (owner_q) begin
            rsp1_out_q <= alu_oval ? alu_out : '0;
            rsp1_err_q <= ~alu_oval;
            rsp1_val_q <= 1'b1;
          end else begin
            rsp0_out_q <= alu_oval ? alu_out : '0;
            rsp0_err_q <= ~alu_oval;
            rsp0_val_q <= 1'b1;
          end
          alu_fn  <= '0;
          alu_imm <= '0;
          alu_in1 <= '0;
          alu_in2 <= '0;
          alu_val <= 1'b0;
          state_q <= StResp;
        end
        StResp: begin
          if (consume) begin
            ops_done_q <= ops_done_q + CNT_W'(1);
            rsp0_val_q <= 1'b0;
            rsp1_val_q <= 1'b0;
            state_q    <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_xalu_ise_arb.sv
module tb_xalu_ise_arb;
  localparam int unsigned XLEN  = 64;
  localparam int unsigned CNT_W = 4;

  logic ise_clk = 1'b0;
  logic ise_rst = 1'b1;
  always #5 ise_clk = ~ise_clk;

  xalu_ise_arb_if #(.XLEN(XLEN)) rq0 ();
  xalu_ise_arb_if #(.XLEN(XLEN)) rq1 ();

  logic [4:0]       alu_fn;
  logic [6:0]       alu_imm;
  logic [XLEN-1:0]  alu_in1, alu_in2, alu_out;
  logic             alu_val, alu_oval;
  logic [CNT_W-1:0] ops_done;
  logic             busy;

  xalu_ise_arb #(.XLEN(XLEN), .RR_INIT(1'b0), .CNT_W(CNT_W)) dut (
    .ise_clk  (ise_clk),
    .ise_rst  (ise_rst),
    .req0     (rq0),
    .req1     (rq1),
    .alu_fn   (alu_fn),
    .alu_imm  (alu_imm),
    .alu_in1  (alu_in1),
    .alu_in2  (alu_in2),
    .alu_val  (alu_val),
    .alu_oval (alu_oval),
    .alu_out  (alu_out),
    .ops_done (ops_done),
    .busy     (busy)
  );

  // Stand-in for xalu_ise: fn==0 is unrecognised; the raw result is nonzero anyway so a
  // missing zeroing shows up.
  assign alu_oval = alu_val && (alu_fn != 5'd0);
  assign alu_out  = (alu_in1 ^ alu_in2) + {52'd0, alu_fn, alu_imm};

  int checks = 0;
  int errors = 0;
  int exp_ops = 0;

  function automatic logic [63:0] alu_model(input logic [4:0] fn, input logic [6:0] imm,
                                            input logic [63:0] in1, input logic [63:0] in2);
    if (fn == 5'd0) return 64'd0;
    return (in1 ^ in2) + {52'd0, fn, imm};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic sel, input logic val, input logic [4:0] fn,
                       input logic [6:0] imm, input logic [63:0] in1, input logic [63:0] in2);
    if (sel) begin
      rq1.req_val = val; rq1.fn = fn; rq1.imm = imm; rq1.in1 = in1; rq1.in2 = in2;
    end else begin
      rq0.req_val = val; rq0.fn = fn; rq0.imm = imm; rq0.in1 = in1; rq0.in2 = in2;
    end
  endtask

  task automatic do_reset();
    @(negedge ise_clk);
    ise_rst = 1'b1;
    rq0.req_val = 1'b0;
    rq1.req_val = 1'b0;
    @(negedge ise_clk);
    ise_rst = 1'b0;
    exp_ops = 0;
  endtask

  // Full accept -> exec -> resp -> consume sequence with rsp_rdy held high.
  task automatic run_op(input string tag, input logic sel, input logic [4:0] fn,
                        input logic [6:0] imm, input logic [63:0] in1, input logic [63:0] in2,
                        input logic [63:0] exp_out, input logic exp_err);
    @(negedge ise_clk);
    drive(sel, 1'b1, fn, imm, in1, in2);
    #1;
    chk({tag, " req_rdy"}, 64'(sel ? rq1.req_rdy : rq0.req_rdy), 64'd1);
    @(negedge ise_clk);
    drive(sel, 1'b0, fn, imm, in1, in2);
    chk({tag, " alu_val"}, 64'(alu_val), 64'd1);
    chk({tag, " alu_fn"}, 64'(alu_fn), 64'(fn));
    chk({tag, " alu_imm"}, 64'(alu_imm), 64'(imm));
    chk({tag, " alu_in1"}, alu_in1, in1);
    chk({tag, " alu_in2"}, alu_in2, in2);
    chk({tag, " busy_exec"}, 64'(busy), 64'd1);
    @(negedge ise_clk);
    chk({tag, " rsp_val"}, 64'(sel ? rq1.rsp_val : rq0.rsp_val), 64'd1);
    chk({tag, " other_rsp_val"}, 64'(sel ? rq0.rsp_val : rq1.rsp_val), 64'd0);
    chk({tag, " rsp_out"}, sel ? rq1.rsp_out : rq0.rsp_out, exp_out);
    chk({tag, " rsp_err"}, 64'(sel ? rq1.rsp_err : rq0.rsp_err), 64'(exp_err));
    chk({tag, " alu_val_off"}, 64'(alu_val), 64'd0);
    chk({tag, " alu_in1_off"}, alu_in1, 64'd0);
    exp_ops++;
    @(negedge ise_clk);
    chk({tag, " rsp_val_drop"}, 64'(sel ? rq1.rsp_val : rq0.rsp_val), 64'd0);
    chk({tag, " ops_done"}, 64'(ops_done), 64'(exp_ops % 16));
    chk({tag, " busy_idle"}, 64'(busy), 64'd0);
  endtask

  typedef struct {
    string       name;
    logic        sel;
    logic [4:0]  fn;
    logic [6:0]  imm;
    logic [63:0] in1;
    logic [63:0] in2;
    logic [63:0] exp_out;
    logic        exp_err;
  } vec_t;

  vec_t vecs[6];

  initial begin
    #20000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [63:0] eo;
    int gcount;
    int last;
    logic exp_sel;

    vecs[0] = '{"sigma_r0",  1'b0, 5'h01, 7'h43, 64'h0000_0000_0000_00F0, 64'h0F,
                64'h1C2, 1'b0};
    vecs[1] = '{"unsup_r1",  1'b1, 5'h00, 7'h00, 64'h1234, 64'h5678, 64'h0, 1'b1};
    vecs[2] = '{"wrap_r1",   1'b1, 5'h0B, 7'h05, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0,
                64'h584, 1'b0};
    vecs[3] = '{"unsup_r0",  1'b0, 5'h00, 7'h7F, 64'h1111, 64'h2222, 64'h0, 1'b1};
    vecs[4] = '{"ones_r0",   1'b0, 5'h1F, 7'h7F, 64'hA5A5_A5A5_A5A5_A5A5,
                64'h5A5A_5A5A_5A5A_5A5A, 64'hFFE, 1'b0};
    vecs[5] = '{"msb_r1",    1'b1, 5'h01, 7'h43, 64'h8000_0000_0000_0000, 64'h1,
                64'h8000_0000_0000_00C4, 1'b0};

    drive(1'b0, 1'b0, 5'd0, 7'd0, 64'd0, 64'd0);
    drive(1'b1, 1'b0, 5'd0, 7'd0, 64'd0, 64'd0);
    rq0.rsp_rdy = 1'b1;
    rq1.rsp_rdy = 1'b1;

    // Reset state
    #2;
    chk("rst rsp0_val", 64'(rq0.rsp_val), 64'd0);
    chk("rst rsp1_val", 64'(rq1.rsp_val), 64'd0);
    chk("rst rsp0_out", rq0.rsp_out, 64'd0);
    chk("rst rsp1_err", 64'(rq1.rsp_err), 64'd0);
    chk("rst alu_val", 64'(alu_val), 64'd0);
    chk("rst alu_in1", alu_in1, 64'd0);
    chk("rst ops_done", 64'(ops_done), 64'd0);
    chk("rst busy", 64'(busy), 64'd0);
    @(negedge ise_clk);
    @(negedge ise_clk);
    ise_rst = 1'b0;

    // Directed vectors
    foreach (vecs[i]) begin
      run_op(vecs[i].name, vecs[i].sel, vecs[i].fn, vecs[i].imm, vecs[i].in1, vecs[i].in2,
             vecs[i].exp_out, vecs[i].exp_err);
    end

    // Round-robin with both requesting continuously
    do_reset();
    drive(1'b0, 1'b1, 5'h01, 7'h43, 64'h10, 64'h20);
    drive(1'b1, 1'b1, 5'h02, 7'h11, 64'h30, 64'h40);
    gcount = 0;
    last = 0;
    exp_sel = 1'b0;
    for (int c = 0; c < 12; c++) begin
      #1;
      if (rq0.req_rdy || rq1.req_rdy) begin
        chk("rr both_rdy", 64'(rq0.req_rdy & rq1.req_rdy), 64'd0);
        chk("rr winner", 64'(rq1.req_rdy), 64'(exp_sel));
        if (gcount > 0) chk("rr gap", 64'(c - last), 64'd3);
        last = c;
        gcount++;
        exp_sel = ~exp_sel;
      end
      @(negedge ise_clk);
    end
    rq0.req_val = 1'b0;
    rq1.req_val = 1'b0;
    chk("rr grants", 64'(gcount), 64'd4);
    chk("rr ops_done", 64'(ops_done), 64'd4);

    // Backpressure on requester 0 while requester 1 waits
    do_reset();
    rq0.rsp_rdy = 1'b0;
    eo = alu_model(5'h01, 7'h43, 64'hDEAD_BEEF, 64'h1234_5678);
    @(negedge ise_clk);
    drive(1'b0, 1'b1, 5'h01, 7'h43, 64'hDEAD_BEEF, 64'h1234_5678);
    drive(1'b1, 1'b1, 5'h02, 7'h11, 64'h77, 64'h88);
    #1;
    chk("bp req0_rdy", 64'(rq0.req_rdy), 64'd1);
    chk("bp req1_rdy_lose", 64'(rq1.req_rdy), 64'd0);
    @(negedge ise_clk);
    rq0.req_val = 1'b0;
    @(negedge ise_clk);
    for (int i = 0; i < 10; i++) begin
      chk("bp rsp0_val", 64'(rq0.rsp_val), 64'd1);
      chk("bp rsp0_out", rq0.rsp_out, eo);
      chk("bp rsp0_err", 64'(rq0.rsp_err), 64'd0);
      chk("bp req1_rdy", 64'(rq1.req_rdy), 64'd0);
      chk("bp rsp1_val", 64'(rq1.rsp_val), 64'd0);
      chk("bp ops_done", 64'(ops_done), 64'd0);
      @(negedge ise_clk);
    end
    rq0.rsp_rdy = 1'b1;
    @(negedge ise_clk);
    chk("bp rsp0_drop", 64'(rq0.rsp_val), 64'd0);
    chk("bp ops_once", 64'(ops_done), 64'd1);
    chk("bp req1_granted", 64'(rq1.req_rdy), 64'd1);
    @(negedge ise_clk);
    rq1.req_val = 1'b0;
    chk("bp r1 alu_fn", 64'(alu_fn), 64'h2);
    @(negedge ise_clk);
    chk("bp r1 rsp_out", rq1.rsp_out, alu_model(5'h02, 7'h11, 64'h77, 64'h88));
    chk("bp rsp0_untouched", rq0.rsp_out, eo);
    @(negedge ise_clk);
    chk("bp ops_two", 64'(ops_done), 64'd2);

    // Reset during EXEC, then during RESP
    do_reset();
    run_op("pre_rst", 1'b0, 5'h03, 7'h01, 64'h5, 64'h6, alu_model(5'h03, 7'h01, 64'h5, 64'h6),
           1'b0);
    @(negedge ise_clk);
    drive(1'b0, 1'b1, 5'h01, 7'h43, 64'h9, 64'hA);
    @(negedge ise_clk);
    rq0.req_val = 1'b0;
    chk("rx exec alu_val", 64'(alu_val), 64'd1);
    ise_rst = 1'b1;
    #1;
    chk("rx alu_val", 64'(alu_val), 64'd0);
    chk("rx busy", 64'(busy), 64'd0);
    chk("rx ops_done", 64'(ops_done), 64'd0);
    chk("rx rsp0_val", 64'(rq0.rsp_val), 64'd0);
    @(negedge ise_clk);
    ise_rst = 1'b0;
    exp_ops = 0;
    @(negedge ise_clk);
    chk("rx no_late_rsp", 64'(rq0.rsp_val), 64'd0);
    rq0.rsp_rdy = 1'b0;
    drive(1'b0, 1'b1, 5'h01, 7'h43, 64'h9, 64'hA);
    @(negedge ise_clk);
    rq0.req_val = 1'b0;
    @(negedge ise_clk);
    chk("rr resp rsp0_val", 64'(rq0.rsp_val), 64'd1);
    ise_rst = 1'b1;
    #1;
    chk("rr rsp0_val", 64'(rq0.rsp_val), 64'd0);
    chk("rr rsp0_out", rq0.rsp_out, 64'd0);
    chk("rr rsp0_err", 64'(rq0.rsp_err), 64'd0);
    chk("rr busy", 64'(busy), 64'd0);
    @(negedge ise_clk);
    ise_rst = 1'b0;
    rq0.rsp_rdy = 1'b1;
    // Priority had moved to requester 1; reset must return it to requester 0.
    rq0.req_val = 1'b1;
    rq1.req_val = 1'b1;
    #1;
    chk("rr prio req0_rdy", 64'(rq0.req_rdy), 64'd1);
    chk("rr prio req1_rdy", 64'(rq1.req_rdy), 64'd0);
    rq0.req_val = 1'b0;
    rq1.req_val = 1'b0;

    // Counter wrap with CNT_W=4: 17 ops -> 1
    do_reset();
    for (int i = 0; i < 17; i++) begin
      logic s;
      logic [63:0] a;
      s = i[0];
      a = 64'(i * 3 + 1);
      run_op("wrap", s, 5'h01, 7'h43, a, 64'h55, alu_model(5'h01, 7'h43, a, 64'h55), 1'b0);
    end
    chk("wrap ops_done", 64'(ops_done), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
